// File: rtl/alu_issue_stage_pkg.sv
// Shared types for the ID/EX issue register: ALU opcodes, operand selects,
// forwarding source tags and the EX slot layout.
package alu_issue_stage_pkg;

    localparam int XLEN    = 32;
    localparam int REG_AW  = 5;
    localparam int NUM_SRC = 2;  // index 0 = rs1, index 1 = rs2

    typedef enum logic [3:0] {
        ALU_add, ALU_sub, ALU_sll, ALU_slt, ALU_sltu, ALU_xor,
        ALU_srl, ALU_sra, ALU_or, ALU_and, ALU_lui, ALU_copy
    } ALU_control_t;

    typedef enum logic { SRC1_RS1, SRC1_PC  } src1_sel_t;
    typedef enum logic { SRC2_RS2, SRC2_IMM } src2_sel_t;
    typedef enum logic [1:0] { FWD_NONE, FWD_MEM, FWD_WB } fwd_sel_t;

    localparam ALU_control_t ALU_NOP_CONTROL = ALU_add;

    typedef struct packed {
        ALU_control_t                          alu;
        logic [XLEN-1:0]                       pc;
        logic [NUM_SRC-1:0][XLEN-1:0]          rs_data;
        logic [XLEN-1:0]                       imm;
        src1_sel_t                             src1_sel;
        src2_sel_t                             src2_sel;
        logic [NUM_SRC-1:0][REG_AW-1:0]        rs_addr;
        logic [NUM_SRC-1:0]                    uses;
        logic [REG_AW-1:0]                     rd;
        logic                                  reg_write;
        logic                                  mem_read;
        logic                                  mem_write;
    } ex_slot_t;

    localparam ex_slot_t EX_SLOT_RST = '{
        alu: ALU_NOP_CONTROL, pc: '0, rs_data: '0, imm: '0,
        src1_sel: SRC1_RS1, src2_sel: SRC2_RS2, rs_addr: '0, uses: '0,
        rd: '0, reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0
    };

    // A writer matches a source only for a live write to a nonzero register.
    function automatic logic reg_hit(input logic valid, input logic we,
                                     input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] rs);
        return valid & we & (rd == rs) & (rs != '0);
    endfunction

endpackage

// File: rtl/alu_issue_stage_operand_forward.sv
// Per-operand bypass selection: MEM result beats WB data beats the raw
// register value captured in the EX slot.
module operand_forward
    import alu_issue_stage_pkg::*;
#(
    parameter bit ENABLE = 1'b1
) (
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [XLEN-1:0]   rs_raw,
    input  logic              mem_valid,
    input  logic              mem_reg_write,
    input  logic              mem_is_load,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [XLEN-1:0]   mem_result,
    input  logic              wb_valid,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output fwd_sel_t          fwd_sel,
    output logic [XLEN-1:0]   fwd_data
);

    always_comb begin
        fwd_sel  = FWD_NONE;
        fwd_data = rs_raw;
        if (ENABLE) begin
            // A load in MEM has no data yet; the load-use stall covers it.
            if (reg_hit(mem_valid & ~mem_is_load, mem_reg_write, mem_rd, rs_addr)) begin
                fwd_sel  = FWD_MEM;
                fwd_data = mem_result;
            end else if (reg_hit(wb_valid, wb_reg_write, wb_rd, rs_addr)) begin
                fwd_sel  = FWD_WB;
                fwd_data = wb_data;
            end
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX boundary register feeding the ALU: valid/ready intake, load-use
// stalling, MEM/WB operand forwarding and operand selection.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter bit ENABLE_FORWARDING = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              id_valid,
    output logic              id_ready,
    input  ALU_control_t      id_alu_control,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [REG_AW-1:0] id_rs1_addr,
    input  logic [REG_AW-1:0] id_rs2_addr,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  src1_sel_t         id_src1_sel,
    input  src2_sel_t         id_src2_sel,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              mem_valid,
    input  logic              mem_reg_write,
    input  logic              mem_is_load,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [XLEN-1:0]   mem_result,
    input  logic              wb_valid,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              ex_valid,
    input  logic              ex_ready,
    output ALU_control_t      ex_alu_control,
    output logic [XLEN-1:0]   ex_data1,
    output logic [XLEN-1:0]   ex_data2,
    output logic [XLEN-1:0]   ex_store_data,
    output logic [XLEN-1:0]   ex_pc,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write
);

    ex_slot_t                       ex_slot_q, ex_slot_d, id_slot;
    logic                           ex_valid_q, ex_valid_d;
    logic                           accept, load_use, raw_stall, hazard;
    logic [NUM_SRC-1:0][REG_AW-1:0] id_rs_addr;
    logic [NUM_SRC-1:0]             id_uses;
    fwd_sel_t                       fwd_sel  [NUM_SRC];
    logic [NUM_SRC-1:0][XLEN-1:0]   fwd_data;

    assign id_rs_addr = {id_rs2_addr, id_rs1_addr};
    assign id_uses    = {id_uses_rs2, id_uses_rs1};

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
        operand_forward #(.ENABLE(ENABLE_FORWARDING)) u_fwd (
            .rs_addr       (ex_slot_q.rs_addr[i]),
            .rs_raw        (ex_slot_q.rs_data[i]),
            .mem_valid     (mem_valid),
            .mem_reg_write (mem_reg_write),
            .mem_is_load   (mem_is_load),
            .mem_rd        (mem_rd),
            .mem_result    (mem_result),
            .wb_valid      (wb_valid),
            .wb_reg_write  (wb_reg_write),
            .wb_rd         (wb_rd),
            .wb_data       (wb_data),
            .fwd_sel       (fwd_sel[i]),
            .fwd_data      (fwd_data[i])
        );
    end

    always_comb begin
        load_use = 1'b0;
        raw_stall = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_uses[i] && ex_valid_q && ex_slot_q.mem_read &&
                ex_slot_q.rd != '0 && id_rs_addr[i] == ex_slot_q.rd)
                load_use = 1'b1;
            // Without bypass paths every in-flight writer is a hazard.
            if (!ENABLE_FORWARDING && id_uses[i] &&
                (reg_hit(ex_valid_q, ex_slot_q.reg_write, ex_slot_q.rd, id_rs_addr[i]) ||
                 reg_hit(mem_valid, mem_reg_write, mem_rd, id_rs_addr[i]) ||
                 reg_hit(wb_valid, wb_reg_write, wb_rd, id_rs_addr[i])))
                raw_stall = 1'b1;
        end
        hazard   = load_use | raw_stall;
        id_ready = ~flush & (~ex_valid_q | ex_ready) & ~hazard;
        accept   = id_valid & id_ready;
    end

    always_comb begin
        id_slot           = EX_SLOT_RST;
        id_slot.alu       = id_alu_control;
        id_slot.pc        = id_pc;
        id_slot.rs_data   = {id_rs2_data, id_rs1_data};
        id_slot.imm       = id_imm;
        id_slot.src1_sel  = id_src1_sel;
        id_slot.src2_sel  = id_src2_sel;
        id_slot.rs_addr   = id_rs_addr;
        id_slot.uses      = id_uses;
        id_slot.rd        = id_rd;
        id_slot.reg_write = id_reg_write;
        id_slot.mem_read  = id_mem_read;
        id_slot.mem_write = id_mem_write;
    end

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_slot_d  = ex_slot_q;
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (accept) begin
            ex_valid_d = 1'b1;
            ex_slot_d  = id_slot;
        end else if (ex_valid_q && ex_ready) begin
            ex_valid_d = 1'b0;
        end else if (ex_valid_q) begin
            // Stalled: capture bypassed values before MEM/WB move on.
            for (int i = 0; i < NUM_SRC; i++)
                if (fwd_sel[i] != FWD_NONE)
                    ex_slot_d.rs_data[i] = fwd_data[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            ex_slot_q  <= EX_SLOT_RST;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_slot_q  <= ex_slot_d;
        end
    end

    always_comb begin
        ex_valid       = ex_valid_q;
        ex_alu_control = ex_slot_q.alu;
        ex_data1       = (ex_slot_q.src1_sel == SRC1_PC)  ? ex_slot_q.pc  : fwd_data[0];
        ex_data2       = (ex_slot_q.src2_sel == SRC2_IMM) ? ex_slot_q.imm : fwd_data[1];
        ex_store_data  = fwd_data[1];
        ex_pc          = ex_slot_q.pc;
        ex_rd          = ex_slot_q.rd;
        ex_reg_write   = ex_valid_q & ex_slot_q.reg_write;
        ex_mem_read    = ex_valid_q & ex_slot_q.mem_read;
        ex_mem_write   = ex_valid_q & ex_slot_q.mem_write;
    end

endmodule
